// File: rtl/spram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spram_pkg
//  Purpose  : Shared types and constants for the SPRAM bank front end.
//  Revision : 1.0  initial release
// ============================================================================
package spram_pkg;

    localparam int c_addr_w = 17;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_STANDBY = 2'd1,
        ST_WAKE    = 2'd2
    } state_e;

    typedef struct packed {
        logic [c_addr_w-1:0] addr;
        logic                we;
        logic [7:0]          wdata;
    } req_t;

endpackage : spram_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Purpose  : Two-input round-robin grant; pointer advances only on a grant.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    // r_prio = 0 favours input 0, 1 favours input 1
    logic r_prio;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = r_prio ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (|grant) begin
            r_prio <= grant[0];
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/spram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : spram_arbiter
//  Purpose  : CPU/DMA round-robin front end for the SPRAM bank with idle standby.
//  Revision : 1.0  initial release
// ============================================================================
module spram_arbiter
    import spram_pkg::*;
#(
    parameter int ADDR_W      = c_addr_w,
    parameter int IDLE_CYCLES = 256,
    parameter int WAKE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic              req_we_0,
    input  logic [7:0]        req_wdata_0,
    output logic              rsp_valid_0,
    output logic [7:0]        rsp_rdata_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic              req_we_1,
    input  logic [7:0]        req_wdata_1,
    output logic              rsp_valid_1,
    output logic [7:0]        rsp_rdata_1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_wren,
    output logic              mem_cs,
    output logic              mem_standby,
    output logic              mem_sleep,
    output logic              mem_poweroff_n,
    input  logic [7:0]        mem_dout
);

    localparam int c_idle_w = $clog2(IDLE_CYCLES + 1);
    localparam int c_wake_w = $clog2(WAKE_CYCLES + 1);

    // The request struct carries the bank's native address width
    if (ADDR_W != c_addr_w) begin : g_addr_w_check
        $error("spram_arbiter: ADDR_W must equal spram_pkg::c_addr_w");
    end

    state_e                r_state;
    state_e                w_state_nxt;
    logic [c_idle_w-1:0]   r_idle_cnt;
    logic [c_wake_w-1:0]   r_wake_cnt;
    logic                  r_rsp_valid;
    logic                  r_rsp_port;
    logic [1:0]            w_valid;
    logic [1:0]            w_grant;
    logic                  w_any;
    logic                  w_arb_en;
    logic                  w_accept;
    logic                  w_sel;
    logic                  w_idle_done;
    logic                  w_wake_done;
    req_t                  w_req [2];

    assign w_req[0]    = '{addr: req_addr_0, we: req_we_0, wdata: req_wdata_0};
    assign w_req[1]    = '{addr: req_addr_1, we: req_we_1, wdata: req_wdata_1};
    assign w_valid     = {req_valid_1, req_valid_0};
    assign w_any       = |w_valid;
    assign w_arb_en    = (r_state == ST_ACTIVE) && !rst;
    assign w_accept    = |w_grant;
    assign w_sel       = w_grant[1];
    assign w_idle_done = (r_idle_cnt == c_idle_w'(IDLE_CYCLES));
    assign w_wake_done = (r_wake_cnt == c_wake_w'(WAKE_CYCLES - 1));

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (w_valid),
        .en    (w_arb_en),
        .grant (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACTIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A request present in the threshold cycle is always granted, so standby
    // entry only needs the no-valid qualifier.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACTIVE:  if (!w_any && w_idle_done) w_state_nxt = ST_STANDBY;
            ST_STANDBY: if (w_any)                 w_state_nxt = ST_WAKE;
            ST_WAKE:    if (w_wake_done)           w_state_nxt = ST_ACTIVE;
            default:                               w_state_nxt = ST_ACTIVE;
        endcase
    end

    always_comb begin
        req_ready_0 = w_grant[0];
        req_ready_1 = w_grant[1];
        mem_cs      = w_accept;
        mem_addr    = '0;
        mem_din     = 8'h00;
        mem_wren    = 1'b0;
        if (w_accept) begin
            mem_addr = w_req[w_sel].addr;
            mem_din  = w_req[w_sel].wdata;
            mem_wren = w_req[w_sel].we;
        end
        mem_standby    = (r_state == ST_STANDBY) && !rst;
        mem_sleep      = 1'b0;
        mem_poweroff_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
        end else begin
            r_idle_cnt <= (r_state == ST_ACTIVE && !w_any && !w_idle_done)
                        ? r_idle_cnt + c_idle_w'(1) : '0;
            r_wake_cnt <= (r_state == ST_WAKE && !w_wake_done)
                        ? r_wake_cnt + c_wake_w'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_port  <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept && !w_req[w_sel].we;
            r_rsp_port  <= w_sel;
        end
    end

    // Read data is the bank output itself; gating by rst drops in-flight reads
    assign rsp_valid_0 = r_rsp_valid && !r_rsp_port && !rst;
    assign rsp_valid_1 = r_rsp_valid &&  r_rsp_port && !rst;
    assign rsp_rdata_0 = rsp_valid_0 ? mem_dout : 8'h00;
    assign rsp_rdata_1 = rsp_valid_1 ? mem_dout : 8'h00;

endmodule : spram_arbiter
`default_nettype wire

// File: tb/tb_spram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spram_arbiter
//  Purpose  : Scoreboard bench for spram_arbiter with a behavioural bank model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spram_arbiter;

    localparam int ADDR_W = 17;
    localparam int IDLE   = 8;
    localparam int WAKE   = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic              req_ready_0, req_ready_1;
    logic [ADDR_W-1:0] req_addr_0 = '0, req_addr_1 = '0;
    logic              req_we_0 = 1'b0, req_we_1 = 1'b0;
    logic [7:0]        req_wdata_0 = '0, req_wdata_1 = '0;
    logic              rsp_valid_0, rsp_valid_1;
    logic [7:0]        rsp_rdata_0, rsp_rdata_1;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_wren, mem_cs, mem_standby, mem_sleep, mem_poweroff_n;
    logic [7:0]        mem_dout = 8'h00;

    spram_arbiter #(.ADDR_W(ADDR_W), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_addr_0(req_addr_0),
        .req_we_0(req_we_0), .req_wdata_0(req_wdata_0),
        .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_addr_1(req_addr_1),
        .req_we_1(req_we_1), .req_wdata_1(req_wdata_1),
        .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren), .mem_cs(mem_cs),
        .mem_standby(mem_standby), .mem_sleep(mem_sleep), .mem_poweroff_n(mem_poweroff_n),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] bank_mem [DEPTH];
    logic [7:0] ref_mem  [DEPTH];

    typedef struct {
        int         cyc;
        int         port;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q [$];

    // Reference model state: mode 0 = active, 1 = standby, 2 = waking
    int         m_mode = 0;
    int         m_idle = 0;
    int         m_wake_left = 0;
    int         m_prio = 0;
    logic [1:0] m_acc = 2'b00;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Single-port bank: 1-cycle registered read
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_cs) begin
            if (mem_wren) bank_mem[mem_addr] <= mem_din;
            else          mem_dout <= bank_mem[mem_addr];
        end
    end

    logic [1:0]        mv;
    int                mg;
    logic              macc;
    logic              msb;
    logic [ADDR_W-1:0] ma;
    logic              mwe;
    logic [7:0]        md;

    // Reference model: predicts the handshake, bank command and read data
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs",
                {req_ready_1, req_ready_0, mem_cs, mem_wren, mem_standby, mem_addr, mem_din},
                64'd0);
            m_mode = 0; m_idle = 0; m_wake_left = 0; m_prio = 0; m_acc = 2'b00;
            exp_q.delete();
        end else begin
            mv   = {req_valid_1, req_valid_0};
            macc = 1'b0;
            mg   = 0;
            msb  = (m_mode == 1);
            case (m_mode)
                0: begin
                    if (mv != 2'b00) begin
                        macc   = 1'b1;
                        mg     = (mv == 2'b11) ? m_prio : (mv[0] ? 0 : 1);
                        m_prio = 1 - mg;
                        m_idle = 0;
                    end else if (m_idle == IDLE) begin
                        m_mode = 1;
                        m_idle = 0;
                    end else begin
                        m_idle++;
                    end
                end
                1: if (mv != 2'b00) begin m_mode = 2; m_wake_left = WAKE; end
                default: begin
                    m_wake_left--;
                    if (m_wake_left == 0) begin m_mode = 0; m_idle = 0; end
                end
            endcase
            m_acc = macc ? ((mg == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk("handshake", {req_ready_1, req_ready_0, mem_cs, mem_standby},
                {m_acc[1], m_acc[0], macc, msb});
            if (macc) begin
                ma  = (mg == 1) ? req_addr_1  : req_addr_0;
                mwe = (mg == 1) ? req_we_1    : req_we_0;
                md  = (mg == 1) ? req_wdata_1 : req_wdata_0;
                chk("mem_cmd", {mem_addr, mem_wren, mem_din}, {ma, mwe, md});
                if (mwe) ref_mem[ma] = md;
                else     exp_q.push_back('{cyc: cyc + 1, port: mg, data: ref_mem[ma]});
            end
        end
    end

    exp_t e;

    // Monitor: pops an expectation whenever the DUT presents a response
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_rsp", {rsp_valid_1, rsp_valid_0, rsp_rdata_1, rsp_rdata_0}, 64'd0);
        end else if (rsp_valid_0 || rsp_valid_1) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {rsp_valid_1, rsp_valid_0}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp", {32'(cyc), rsp_valid_1, rsp_valid_0, rsp_rdata_1, rsp_rdata_0},
                    {32'(e.cyc), e.port == 1, e.port == 0,
                     (e.port == 1) ? e.data : 8'h00, (e.port == 0) ? e.data : 8'h00});
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("rsp_missing", 64'd0, {32'(e.cyc), 8'(e.port)});
        end else begin
            chk("rsp_quiet", {rsp_rdata_1, rsp_rdata_0}, 64'd0);
        end
    end

    task automatic set_req(input int p, input logic v, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [7:0] d);
        if (p == 0) begin
            req_valid_0 = v; req_we_0 = we; req_addr_0 = a; req_wdata_0 = d;
        end else begin
            req_valid_1 = v; req_we_1 = we; req_addr_1 = a; req_wdata_1 = d;
        end
    endtask

    // Single-port request held until accepted; lat = cycles spent waiting
    task automatic send(input int p, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [7:0] d, output int lat);
        @(posedge clk); #1;
        set_req(1 - p, 1'b0, 1'b0, '0, 8'h00);
        set_req(p, 1'b1, we, a, d);
        lat = 0;
        forever begin
            @(negedge clk); #1;
            if (m_acc[p]) break;
            lat++;
            if (lat >= 40) begin
                checks++; errors++;
                $display("FAIL send_timeout: port %0d not accepted within %0d cycles", p, lat);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [ADDR_W-1:0] base;
        base = ($urandom_range(0, 1) == 1) ? ADDR_W'(DEPTH - 16) : '0;
        return base + ADDR_W'($urandom_range(0, 15));
    endfunction

    task automatic rand_phase(input int n, input int dens);
        repeat (n) begin
            @(posedge clk); #1;
            if (!req_valid_0 || m_acc[0]) begin
                if (int'($urandom_range(0, 99)) < dens)
                    set_req(0, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
                else
                    req_valid_0 = 1'b0;
            end
            if (!req_valid_1 || m_acc[1]) begin
                if (int'($urandom_range(0, 99)) < dens)
                    set_req(1, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
                else
                    req_valid_1 = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    logic [3:0] seq;
    int         lat;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            bank_mem[i] = 8'((i * 37) ^ (i >> 9));
            ref_mem[i]  = 8'((i * 37) ^ (i >> 9));
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Both ports hold reads: fresh pointer gives grants 0,1,0,1
        set_req(0, 1'b1, 1'b0, 17'h00010, 8'h00);
        set_req(1, 1'b1, 1'b0, 17'h18000, 8'h00);
        seq = 4'b0000;
        repeat (4) begin
            @(negedge clk); #1;
            seq = {seq[2:0], req_ready_0};
        end
        chk("rr_alternate", 64'(seq), 64'(4'b1010));

        // Write then read back on port 0
        send(0, 1'b1, 17'h12345, 8'hA5, lat);
        chk("write_latency", 64'(lat), 64'd0);
        send(0, 1'b0, 17'h12345, 8'h00, lat);
        idle(3);

        // Idle into standby
        idle(IDLE + 4);
        @(negedge clk); #1;
        chk("standby_entered", {mem_standby, mem_cs}, 64'(2'b10));

        // Wake from standby by a port 1 read
        send(1, 1'b0, 17'h1FFFF, 8'h00, lat);
        chk("wake_latency", 64'(lat), 64'(WAKE + 1));

        // Request exactly in the threshold cycle is accepted without standby
        send(0, 1'b1, 17'h00001, 8'h3C, lat);
        idle(8);
        send(1, 1'b0, 17'h00001, 8'h00, lat);
        chk("threshold_accept", 64'(lat), 64'd0);

        // Reset in the cycle after a read accept
        send(0, 1'b0, 17'h00100, 8'h00, lat);
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 17'h00200, 8'h00);
        set_req(1, 1'b1, 1'b0, 17'h00300, 8'h00);
        @(negedge clk); #1;
        chk("rr_after_reset", {req_ready_1, req_ready_0}, 64'(2'b01));
        @(posedge clk); #1;
        req_valid_0 = 1'b0;
        @(posedge clk); #1;
        req_valid_1 = 1'b0;

        // Randomized traffic at several densities, then drain
        rand_phase(150, 70);
        rand_phase(200, 6);
        rand_phase(100, 90);
        rand_phase(40, 0);
        idle(5);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        chk("mem_sleep_poweroff", {mem_sleep, mem_poweroff_n}, 64'(2'b01));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_spram_arbiter
`default_nettype wire

// File: doc/spram_arbiter.md
# spram_arbiter

Two-requester front end for the 128 KiB single-port SPRAM bank (four 256 Kbit primitives, byte-addressed, 1-cycle read latency). Arbitrates round-robin between a CPU-side port and a DMA-side port with valid/ready handshakes and accepts at most one access per cycle. Routes each read response back to the port that issued it. Automatically places the bank in standby after a configurable idle period and wakes it on demand.

## Interface
Parameters:
- `ADDR_W`, 17: byte address width; matches the bank.
- `IDLE_CYCLES`, 256: consecutive cycles with no accepted request before standby entry; minimum 1.
- `WAKE_CYCLES`, 2: cycles standby must be deasserted before the first access; minimum 1.

Ports (x = 0 for the CPU port, x = 1 for the DMA port):
- `clk`  in  1  single clock; memory clock is the same net.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid_x`  in  1  request present.
- `req_ready_x`  out  1  request accepted this cycle when high together with valid.
- `req_addr_x`  in  ADDR_W  byte address.
- `req_we_x`  in  1  1 = write, 0 = read.
- `req_wdata_x`  in  8  write byte.
- `rsp_valid_x`  out  1  read data valid.
- `rsp_rdata_x`  out  8  read byte; 0 when `rsp_valid_x` = 0.
- `mem_addr`  out  ADDR_W, `mem_din`  out  8, `mem_wren`  out  1, `mem_cs`  out  1: memory command.
- `mem_standby`  out  1, `mem_sleep`  out  1 (tied 0), `mem_poweroff_n`  out  1 (tied 1).
- `mem_dout`  in  8  byte read data from the bank.

## Operation
- FSM states: ACTIVE, STANDBY, WAKE. Reset state is ACTIVE.
- ACTIVE:
  - If exactly one port is valid, that port is granted.
  - If both are valid, the port not granted last is granted; the round-robin pointer updates only on an accepted transfer. After reset the pointer favours port 0.
  - The granted port sees `req_ready_x` = 1. `mem_cs` = 1 and the mem_* command comes from the granted port. `mem_wren` = `req_we` of the granted port.
- Idle counter:
  - Clears on every accepted request and otherwise increments in ACTIVE.
  - When the counter reaches IDLE_CYCLES with no valid request present → STANDBY.
  - A valid request in the threshold cycle wins: it is accepted, the counter clears, and there is no standby.
- STANDBY: `mem_standby` = 1, `mem_cs` = 0, all readies 0. Any `req_valid_x` → WAKE.
- WAKE: `mem_standby` = 0, `mem_cs` = 0, readies 0. Counts WAKE_CYCLES, then → ACTIVE. Pending requests are granted normally in the first ACTIVE cycle.
- Writes produce no response. A read produces exactly one `rsp_valid_x` pulse on the issuing port.
- Requesters must hold addr/we/wdata stable while valid is high and not accepted.

## Timing
- `req_ready_x` is combinational from `req_valid_*`, the FSM state and the pointer. The mem_* command is combinational from the granted request.
- Read accepted at edge N → `rsp_valid_x` high for the cycle after edge N. In that cycle `rsp_rdata_x` = `mem_dout`, passed through combinationally. Total read latency is 1 cycle.
- Back-to-back: one accept per cycle sustained. A read on port 0 followed by a read on port 1 gives responses on consecutive cycles on their own ports.
- Reset values: all readies 0 during reset, `rsp_valid_x` = 0, `rsp_rdata_x` = 0, `mem_cs` = 0, `mem_wren` = 0, `mem_standby` = 0, `mem_addr`/`mem_din` = 0, counters 0.
- Reset mid-read: an in-flight response is dropped, with no `rsp_valid` after reset.

## Structure
- Package `spram_pkg`: the `ADDR_W` default constant, the FSM state enum (ACTIVE/STANDBY/WAKE), and the request struct (addr, we, wdata).
- Sub-module `rr_arbiter2`: two-input round-robin grant with a pointer that updates on accept. It is reused by later multi-master memory blocks.
- Top level holds the FSM, the idle/wake counters, the response-port register, and the command mux.

## Test plan
- Port 0 writes 0xA5 to 0x1_2345, then reads 0x1_2345 → `rsp_valid_0` one cycle after accept, `rsp_rdata_0` = 0xA5, `rsp_valid_1` stays 0.
- Both ports hold reads (0x00010, 0x18000) for 4 cycles → grants alternate 0,1,0,1; responses return on the matching ports with the correct data.
- No requests for IDLE_CYCLES = 8 → `mem_standby` rises after 8 idle cycles, with `mem_cs` = 0.
- In standby, port 1 raises a read → WAKE lasts WAKE_CYCLES = 2 with ready 0 throughout; accepted in the first ACTIVE cycle; data is correct.
- A request arrives exactly at the IDLE_CYCLES threshold → accepted, no standby pulse.
- `rst` asserted in the cycle after a read accept → no `rsp_valid`; all outputs at reset values; the pointer favours port 0 afterwards.
